pe_rs_engine: RTL

//  Parametrised next-gen Eyeriss row-stationary PE: packed-free element streams, signed MAC, configurable stride.

---
 rtl/pe_rs_engine_pkg.sv | 41 ++++
 rtl/pe_rs_engine_mac.sv | 37 +++
 rtl/pe_rs_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_rs_engine_pkg.sv
// Shared opcode/state types and helpers for the row-stationary PE.
package pe_rs_engine_pkg;

   localparam int CW = 16;

   typedef enum logic [2:0] {
      OP_SET  = 3'b000,
      OP_LIF  = 3'b001,
      OP_LWG  = 3'b010,
      OP_CONV = 3'b011,
      OP_ACC  = 3'b100,
      OP_SHF  = 3'b101,
      OP_DRN  = 3'b110,
      OP_NOP  = 3'b111
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEC,
      ST_LIF,
      ST_LWG,
      ST_SHF,
      ST_CONV,
      ST_ACC,
      ST_DRN
   } state_t;

   // (a + b) mod m, valid when a < m and b <= m
   function automatic logic [4:0] wrap_add(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic [3:0] m
   );
      logic [4:0] t;
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, m})
         t = t - {1'b0, m};
      return t;
   endfunction

endpackage

// File: rtl/pe_rs_engine_mac.sv
// Signed element multiply plus saturating psum add.
module pe_rs_engine_mac
   import pe_rs_engine_pkg::*;
#(
   parameter int EWIDTH   = 8,
   parameter int PWIDTH   = 32,
   parameter int SATURATE = 1
) (
   input  logic              mul_en,
   input  logic [EWIDTH-1:0] a,
   input  logic [EWIDTH-1:0] b,
   input  logic [PWIDTH-1:0] addend,
   input  logic [PWIDTH-1:0] acc,
   output logic [PWIDTH-1:0] sum
);

   localparam logic [PWIDTH-1:0] MAXV = {1'b0, {(PWIDTH-1){1'b1}}};
   localparam logic [PWIDTH-1:0] MINV = {1'b1, {(PWIDTH-1){1'b0}}};

   logic [2*EWIDTH-1:0] prod;
   logic [PWIDTH-1:0]   opnd;
   logic [PWIDTH:0]     wide;

   always_comb begin
      prod = $signed({{EWIDTH{a[EWIDTH-1]}}, a})
           * $signed({{EWIDTH{b[EWIDTH-1]}}, b});
      opnd = mul_en
           ? {{(PWIDTH-2*EWIDTH){prod[2*EWIDTH-1]}}, prod}
           : addend;
      wide = {acc[PWIDTH-1], acc} + {opnd[PWIDTH-1], opnd};
      if (SATURATE != 0 && wide[PWIDTH] != wide[PWIDTH-1])
         sum = wide[PWIDTH] ? MINV : MAXV;
      else
         sum = wide[PWIDTH-1:0];
   end

endmodule

// File: rtl/pe_rs_engine.sv
// Row-stationary PE: ifmap/weight spads, psum RF, opcode-sequenced MAC.
module pe_rs_engine
   import pe_rs_engine_pkg::*;
#(
   parameter int EWIDTH      = 8,
   parameter int PWIDTH      = 32,
   parameter int IFMAP_DEPTH = 16,
   parameter int WGHT_DEPTH  = 128,
   parameter int PSUM_DEPTH  = 8,
   parameter int SATURATE    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [2:0]        i_opcode,
   input  logic              i_opcode_valid,
   output logic              o_opcode_ready,
   input  logic [4:0]        i_layer_p,
   input  logic [2:0]        i_layer_q,
   input  logic [3:0]        i_layer_s,
   input  logic [3:0]        i_layer_u,
   input  logic [EWIDTH-1:0] i_ifmap_data,
   input  logic              i_ifmap_valid,
   output logic              o_ifmap_ready,
   input  logic [EWIDTH-1:0] i_wght_data,
   input  logic              i_wght_valid,
   output logic              o_wght_ready,
   input  logic [PWIDTH-1:0] i_psum_in_data,
   input  logic              i_psum_in_valid,
   output logic              o_psum_in_ready,
   output logic [PWIDTH-1:0] o_psum_out_data,
   output logic              o_psum_out_valid,
   input  logic              i_psum_out_ready
);

   localparam int IA = $clog2(IFMAP_DEPTH);
   localparam int WA = $clog2(WGHT_DEPTH);
   localparam int PA = $clog2(PSUM_DEPTH);

   state_t            state;
   op_t               op;
   logic [4:0]        p_r;
   logic [2:0]        q_r;
   logic [3:0]        s_r, u_r, base;
   logic [CW-1:0]     cnt, total;
   logic [PA-1:0]     cp;
   logic [2:0]        cq;
   logic [3:0]        cs;
   logic [EWIDTH-1:0] ifm [IFMAP_DEPTH];
   logic [EWIDTH-1:0] wgt [WGHT_DEPTH];
   logic [PWIDTH-1:0] psum [PSUM_DEPTH];
   logic              s2_v;
   logic [PA-1:0]     s2_p;
   logic [EWIDTH-1:0] s2_a, s2_b;
   logic [PWIDTH-1:0] out_data, mac_add, mac_sum;
   logic              out_valid;
   logic [3:0]        col;
   logic [IA-1:0]     if_addr;
   logic [WA-1:0]     w_addr;
   logic [PA-1:0]     rf_idx;
   logic more, out_free, if_beat, w_beat, conv_iss, pop;

   assign more            = cnt < total;
   assign out_free        = !out_valid || i_psum_out_ready;
   assign o_opcode_ready  = state == ST_IDLE;
   assign o_ifmap_ready   = (state == ST_LIF || state == ST_SHF) && more;
   assign o_wght_ready    = state == ST_LWG && more;
   assign o_psum_in_ready = state == ST_ACC && more && out_free;
   assign o_psum_out_data  = out_data;
   assign o_psum_out_valid = out_valid;

   assign if_beat  = o_ifmap_ready && i_ifmap_valid;
   assign w_beat   = o_wght_ready && i_wght_valid;
   assign conv_iss = state == ST_CONV && more;
   assign pop      = (o_psum_in_ready && i_psum_in_valid)
                  || (state == ST_DRN && more && out_free);

   // Window column s lives at physical column (base+s) mod S
   assign col     = 4'(wrap_add(base, cs, s_r));
   assign if_addr = IA'(CW'(col) * CW'(q_r) + CW'(cq));
   assign w_addr  = WA'(cnt);
   assign rf_idx  = s2_v ? s2_p : PA'(cnt);
   assign mac_add = state == ST_ACC ? i_psum_in_data : '0;

   pe_rs_engine_mac #(
      .EWIDTH  (EWIDTH),
      .PWIDTH  (PWIDTH),
      .SATURATE(SATURATE)
   ) u_mac (
      .mul_en(s2_v),
      .a     (s2_a),
      .b     (s2_b),
      .addend(mac_add),
      .acc   (psum[rf_idx]),
      .sum   (mac_sum)
   );

   always_ff @(posedge i_clk) begin
      if (if_beat)
         ifm[if_addr] <= i_ifmap_data;
      if (w_beat)
         wgt[w_addr] <= i_wght_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         op        <= OP_NOP;
         p_r       <= '0;
         q_r       <= '0;
         s_r       <= '0;
         u_r       <= '0;
         base      <= '0;
         cnt       <= '0;
         total     <= '0;
         cp        <= '0;
         cq        <= '0;
         cs        <= '0;
         s2_v      <= 1'b0;
         s2_p      <= '0;
         s2_a      <= '0;
         s2_b      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < PSUM_DEPTH; i++)
            psum[i] <= '0;
      end else begin
         s2_v <= conv_iss;
         if (conv_iss) begin
            s2_p <= cp;
            s2_a <= ifm[if_addr];
            s2_b <= wgt[w_addr];
         end
         if (s2_v)
            psum[s2_p] <= mac_sum;
         if (pop) begin
            psum[PA'(cnt)] <= '0;
            out_data  <= mac_sum;
            out_valid <= 1'b1;
         end else if (i_psum_out_ready) begin
            out_valid <= 1'b0;
         end
         // Beat counters nest as p { s { q } }
         if (if_beat || w_beat || conv_iss || pop) begin
            cnt <= cnt + 1'b1;
            if (cq == q_r - 1'b1) begin
               cq <= '0;
               if (cs == s_r - 1'b1) begin
                  cs <= '0;
                  cp <= cp + 1'b1;
               end else begin
                  cs <= cs + 1'b1;
               end
            end else begin
               cq <= cq + 1'b1;
            end
         end
         unique case (state)
            ST_IDLE: if (i_opcode_valid) begin
               op    <= op_t'(i_opcode);
               state <= ST_DEC;
            end
            ST_DEC: begin
               cnt <= '0;
               cp  <= '0;
               cq  <= '0;
               cs  <= '0;
               unique case (op)
                  OP_SET: begin
                     p_r   <= i_layer_p;
                     q_r   <= i_layer_q;
                     s_r   <= i_layer_s;
                     u_r   <= i_layer_u;
                     state <= ST_IDLE;
                  end
                  OP_LIF: begin
                     total <= CW'(q_r) * CW'(s_r);
                     base  <= '0;
                     state <= ST_LIF;
                  end
                  OP_LWG: begin
                     total <= CW'(p_r) * CW'(q_r) * CW'(s_r);
                     state <= ST_LWG;
                  end
                  OP_SHF: begin
                     total <= CW'(u_r) * CW'(q_r);
                     state <= ST_SHF;
                  end
                  OP_CONV: begin
                     total <= CW'(p_r) * CW'(q_r) * CW'(s_r);
                     state <= ST_CONV;
                  end
                  OP_ACC: begin
                     total <= CW'(p_r);
                     state <= ST_ACC;
                  end
                  OP_DRN: begin
                     total <= CW'(p_r);
                     state <= ST_DRN;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
            ST_LIF, ST_LWG, ST_CONV: if (!more)
               state <= ST_IDLE;
            ST_SHF: if (!more) begin
               base  <= 4'(wrap_add(base, u_r, s_r));
               state <= ST_IDLE;
            end
            ST_ACC, ST_DRN: if (!more && out_free)
               state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
